// File: rtl/shared_data_ram.sv
// shared_data_ram: data memory shared by NUM_CORES cores through a round-robin
// arbiter that accepts one access per clock. Writes land at the grant edge;
// reads return on a per-core registered bus with a one-cycle rdValid pulse.
// Handshake: core k holds req/wrEn/addr/dataIn stable while req[k]=1; the
// access completes at the posedge where req[k] & gnt[k]; dropping req before
// a grant abandons the access.
// Optional simulation feature, macro SHARED_DATA_RAM_DUMP_EN: memory dump on
// a processDone rising edge, per-core grant counters.
module shared_data_ram #(
  parameter int mem_init   = 0,
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int NUM_CORES  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CORES-1:0]            req,
  input  logic [NUM_CORES-1:0]            wrEn,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_CORES*WIDTH-1:0]      dataIn,
  output logic [NUM_CORES-1:0]            gnt,
  output logic [NUM_CORES*WIDTH-1:0]      dataOut,
  output logic [NUM_CORES-1:0]            rdValid,
  input  logic                            processDone
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [PTR_W:0]      NC_W    = (PTR_W+1)'(NUM_CORES);
  localparam logic [PTR_W-1:0]    LAST_PT = PTR_W'(NUM_CORES - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  logic [PTR_W-1:0]           ptr_q, ptr_d;
  logic [NUM_CORES-1:0]       gnt_d;
  logic                       grant_any;
  logic [PTR_W-1:0]           gnt_idx;
  logic [ADDR_WIDTH-1:0]      sel_addr;
  logic [WIDTH-1:0]           sel_data;
  logic                       sel_wr;
  logic                       sel_in_range;
  logic [WIDTH-1:0]           rd_word;
  logic [WIDTH-1:0]           mem_q [DEPTH];
  logic [NUM_CORES*WIDTH-1:0] data_out_q, data_out_d;
  logic [NUM_CORES-1:0]       rd_valid_q, rd_valid_d;

  // Round-robin search starting at ptr_q, wrapping modulo NUM_CORES; reset masks all grants.
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] cand;
    gnt_d     = '0;
    grant_any = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(i);
      if (sum >= NC_W) sum = sum - NC_W;
      cand = sum[PTR_W-1:0];
      if (!grant_any && req[cand] && !rst) begin
        grant_any   = 1'b1;
        gnt_d[cand] = 1'b1;
        gnt_idx     = cand;
      end
    end
  end

  assign gnt = gnt_d;

  // Pointer moves to the core after the winner; it holds when nobody is granted.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = (gnt_idx == LAST_PT) ? '0 : gnt_idx + PTR_W'(1);
  end

  // Route the winning core's request fields to the memory port.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_wr   = 1'b0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (gnt_d[k]) begin
        sel_addr = addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = dataIn[k*WIDTH +: WIDTH];
        sel_wr   = wrEn[k];
      end
    end
    sel_in_range = ({1'b0, sel_addr} < DEPTH_W);
    rd_word      = sel_in_range ? mem_q[sel_addr] : '0;
  end

  // Only the granted reader's slice is loaded; other slices keep their last read.
  always_comb begin
    data_out_d = data_out_q;
    rd_valid_d = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (gnt_d[k] && !sel_wr) begin
        data_out_d[k*WIDTH +: WIDTH] = rd_word;
        rd_valid_d[k]                = 1'b1;
      end
    end
  end

  // Memory array: no reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (grant_any && sel_wr && sel_in_range) mem_q[sel_addr] <= sel_data;
  end

  // Arbiter pointer and read-return registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign dataOut = data_out_q;
  assign rdValid = rd_valid_q;

`ifdef SHARED_DATA_RAM_DUMP_EN
  logic        done_q;
  logic [31:0] acc_cnt_q [NUM_CORES];

  // Grant counters plus a dump on every rising edge of processDone.
  always_ff @(posedge clk) begin
    done_q <= processDone;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (rst)           acc_cnt_q[k] <= '0;
      else if (gnt_d[k]) acc_cnt_q[k] <= acc_cnt_q[k] + 32'd1;
    end
    if (processDone && !done_q) begin
      for (int a = 0; a < DEPTH; a++)
        $display("shared_data_ram: mem[%0d] = %b", a, mem_q[a]);
      for (int k = 0; k < NUM_CORES; k++)
        $display("shared_data_ram: core %0d accesses = %0d (mem_init=%0d)", k, acc_cnt_q[k], mem_init);
    end
  end
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, processDone, (mem_init != 0)};
`endif

endmodule

// File: tb/tb_shared_data_ram.sv
// Bench for shared_data_ram: two instances (DEPTH 4096 and DEPTH 3000) share
// one stimulus; a behavioural model predicts grants, memory and read returns.
module tb_shared_data_ram;
  localparam int N  = 4;
  localparam int W  = 12;
  localparam int D  = 4096;
  localparam int D2 = 3000;
  localparam int AW = 12;
  localparam int PW = 2;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    wr_en = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*W-1:0]  data_in = '0;
  logic            process_done = 1'b0;
  logic [N-1:0]    gnt_a, gnt_b, rdv_a, rdv_b;
  logic [N*W-1:0]  dout_a, dout_b;

  always #5 clk = ~clk;

  shared_data_ram #(.mem_init(0), .WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .NUM_CORES(N)) dut_a (
    .clk(clk), .rst(rst), .req(req), .wrEn(wr_en), .addr(addr), .dataIn(data_in),
    .gnt(gnt_a), .dataOut(dout_a), .rdValid(rdv_a), .processDone(process_done));

  shared_data_ram #(.mem_init(0), .WIDTH(W), .DEPTH(D2), .ADDR_WIDTH(AW), .NUM_CORES(N)) dut_b (
    .clk(clk), .rst(rst), .req(req), .wrEn(wr_en), .addr(addr), .dataIn(data_in),
    .gnt(gnt_b), .dataOut(dout_b), .rdValid(rdv_b), .processDone(process_done));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0]   m_mem_a [D];
  logic [W-1:0]   m_mem_b [D2];
  logic [N*W-1:0] m_dout_a, m_dout_b;
  logic [N-1:0]   m_rdv, m_gnt;
  int             m_ptr = 0;
  int             m_rd_core = 0;
  bit             chk_on = 1'b0;
  logic [W-1:0]   exp_q[$];
  logic [W-1:0]   exp_b_q[$];

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (r[j[PW-1:0]]) return j;
    end
    return -1;
  endfunction

  // Compare the DUT against the model, then advance the model to the next posedge.
  always @(negedge clk) begin
    int k, a, d;
    logic [N-1:0] eg;
    logic [W-1:0] ra, rb;
    k  = rr_pick(req, m_ptr);
    eg = '0;
    if (!rst && k >= 0) eg[k[PW-1:0]] = 1'b1;
    if (chk_on) begin
      chk("gnt_a", 64'(gnt_a), 64'(eg));
      chk("gnt_b", 64'(gnt_b), 64'(eg));
      chk("rdv_a", 64'(rdv_a), 64'(m_rdv));
      chk("rdv_b", 64'(rdv_b), 64'(m_rdv));
      chk("dout_a", 64'(dout_a), 64'(m_dout_a));
      chk("dout_b", 64'(dout_b), 64'(m_dout_b));
      if (m_rdv != '0) begin
        if (exp_q.size() == 0 || exp_b_q.size() == 0) begin
          chk("read_queue_empty", 64'd1, 64'd0);
        end else begin
          chk("read_data_a", 64'(dout_a[m_rd_core*W +: W]), 64'(exp_q.pop_front()));
          chk("read_data_b", 64'(dout_b[m_rd_core*W +: W]), 64'(exp_b_q.pop_front()));
        end
      end
    end
    m_gnt = eg;
    if (rst) begin
      m_ptr    = 0;
      m_rdv    = '0;
      m_dout_a = '0;
      m_dout_b = '0;
      exp_q.delete();
      exp_b_q.delete();
      chk_on   = 1'b1;
    end else begin
      m_rdv = '0;
      if (k >= 0) begin
        a = int'(addr[k*AW +: AW]);
        d = int'(data_in[k*W +: W]);
        if (wr_en[k[PW-1:0]]) begin
          m_mem_a[a] = W'(d);
          if (a < D2) m_mem_b[a] = W'(d);
        end else begin
          ra = m_mem_a[a];
          rb = (a < D2) ? m_mem_b[a] : '0;
          m_dout_a[k*W +: W] = ra;
          m_dout_b[k*W +: W] = rb;
          m_rdv[k[PW-1:0]]   = 1'b1;
          m_rd_core          = k;
          exp_q.push_back(ra);
          exp_b_q.push_back(rb);
        end
        m_ptr = (k + 1) % N;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic w, input int a, input int d);
    req[k]               = 1'b1;
    wr_en[k]             = w;
    addr[k*AW +: AW]     = AW'(a);
    data_in[k*W +: W]    = W'(d);
  endtask

  task automatic new_req(input int k);
    int a;
    case ($urandom_range(0, 3))
      0:       a = int'($urandom_range(2990, 3010));
      1:       a = int'($urandom_range(0, 15));
      default: a = int'($urandom_range(0, D - 1));
    endcase
    drive(k, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 4095)));
  endtask

  task automatic report();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
  endtask

  initial begin
    #2_000_000;
    chk("watchdog_timeout", 64'd1, 64'd0);
    report();
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    int cnt [N];
    logic [N-1:0] exp_g;
    for (int k = 0; k < N; k++) cnt[k] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rdv", 64'(rdv_a), 64'd0);
    chk("reset_dout", 64'(dout_a), 64'd0);
    chk("reset_gnt", 64'(gnt_a), 64'd0);
    step();

    // Round-robin with all cores requesting
    for (int k = 0; k < N; k++) drive(k, 1'b1, k, k + 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp_g = '0;
      exp_g[i % N] = 1'b1;
      chk("rr_order", 64'(gnt_a), 64'(exp_g));
      for (int k = 0; k < N; k++) if (gnt_a[k]) cnt[k]++;
      step();
    end
    req = '0;
    for (int k = 0; k < N; k++) chk("rr_count", 64'(cnt[k]), 64'd2);

    // Preload every word through core 0
    for (int a = 0; a < D; a++) begin
      drive(0, 1'b1, a, int'($urandom_range(0, 4095)));
      step();
    end

    // Single write / read on core 0 (pointer now 1)
    drive(0, 1'b1, 5, 12'hABC);
    @(negedge clk);
    chk("wr_gnt", 64'(gnt_a), 64'b0001);
    step();
    drive(0, 1'b0, 5, 0);
    @(negedge clk);
    chk("rd_gnt", 64'(gnt_a), 64'b0001);
    step();
    req = '0;
    @(negedge clk);
    chk("rd_valid", 64'(rdv_a), 64'b0001);
    chk("rd_data", 64'(dout_a[11:0]), 64'hABC);
    chk("rd_data_b", 64'(dout_b[11:0]), 64'hABC);
    step();

    // Skip idle cores: ptr=1, req=1001
    drive(0, 1'b0, 0, 0);
    drive(3, 1'b0, 0, 0);
    @(negedge clk);
    chk("skip_first", 64'(gnt_a), 64'b1000);
    step();
    req[3] = 1'b0;
    @(negedge clk);
    chk("skip_second", 64'(gnt_a), 64'b0001);
    step();
    for (int k = 0; k < N; k++) drive(k, 1'b0, 0, 0);
    @(negedge clk);
    chk("skip_ptr_end", 64'(gnt_a), 64'b0010);
    step();
    req = '0;

    // Cross-core coherence at the top address (pointer now 2)
    drive(2, 1'b1, 4095, 12'h123);
    @(negedge clk);
    chk("coh_wr_gnt", 64'(gnt_a), 64'b0100);
    step();
    req = '0;
    drive(3, 1'b0, 4095, 0);
    @(negedge clk);
    chk("coh_rd_gnt", 64'(gnt_a), 64'b1000);
    step();
    req = '0;
    @(negedge clk);
    chk("coh_valid", 64'(rdv_a), 64'b1000);
    chk("coh_data", 64'(dout_a[47:36]), 64'h123);
    chk("coh_oor_valid_b", 64'(rdv_b), 64'b1000);
    chk("coh_oor_data_b", 64'(dout_b[47:36]), 64'h0);
    step();

    // Out of range on the 3000-word instance
    drive(0, 1'b1, 3001, 12'hFFF);
    @(negedge clk);
    chk("oor_wr_gnt_b", 64'(gnt_b), 64'b0001);
    step();
    drive(0, 1'b0, 3001, 0);
    step();
    req = '0;
    @(negedge clk);
    chk("oor_valid_b", 64'(rdv_b), 64'b0001);
    chk("oor_data_b", 64'(dout_b[11:0]), 64'h0);
    chk("inrange_data_a", 64'(dout_a[11:0]), 64'hFFF);
    step();

    // Randomized traffic with hold-until-grant and occasional abandonment
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!req[k] || m_gnt[k]) begin
          if ($urandom_range(0, 9) < 7) new_req(k);
          else req[k] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          req[k] = 1'b0;
        end
      end
      step();
    end
    req = '0;
    step();
    step();

    // Reset in the cycle after a read grant
    drive(0, 1'b0, 7, 0);
    @(negedge clk);
    chk("mid_rd_gnt", 64'(gnt_a), 64'b0001);
    step();
    for (int k = 0; k < N; k++) drive(k, 1'b0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_pulse", 64'(rdv_a), 64'b0001);
    chk("mid_gnt_forced", 64'(gnt_a), 64'b0000);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rdv_clr", 64'(rdv_a), 64'd0);
    chk("mid_dout_clr", 64'(dout_a), 64'd0);
    chk("mid_first_gnt", 64'(gnt_a), 64'b0001);
    step();
    req = '0;

    // Read back every word; the model checks both instances
    for (int a = 0; a < D; a++) begin
      drive(0, 1'b0, a, 0);
      step();
    end
    req = '0;
    step();
    step();

    report();
    $finish;
  end
endmodule
